// File: rtl/bin_to_bcd_display.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding the
// 8-digit seven-segment driver, with optional leading-zero blanking and an overflow word.
module bin_to_bcd_display #(
    parameter bit          BLANK_LEADING = 1'b1,
    parameter logic [31:0] OVF_CODE      = 32'hEEEEEEEE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [26:0] in_value,
    output logic        in_ready,
    output logic [31:0] data_out,
    output logic        out_valid,
    output logic        overflow
);

    localparam int unsigned BIN_W  = 27;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = 5;

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0] MAX_VALUE  = BIN_W'(99_999_999);
    localparam logic [BCD_W-1:0] RESET_WORD = BLANK_LEADING ? 32'hFFFFFFF0 : 32'h00000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FINISH  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_pending_q, ovf_pending_d;
    logic [BCD_W-1:0]  data_out_d;
    logic              out_valid_d;
    logic              overflow_d;
    logic              in_ready_d;

    // Add 3 to every nibble that is 5 or more (4-bit add, carry discarded).
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r = b;
        for (int i = 0; i < int'(DIGITS); i++) begin
            nib = b[4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            r[4*i +: 4] = nib;
        end
        return r;
    endfunction

    // Replace leading zero digits (digit7..digit1) with 4'hF; digit0 always shown.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic             leading;
        r       = b;
        leading = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (leading && (b[4*i +: 4] == 4'h0)) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            bin_q         <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            ovf_pending_q <= 1'b0;
            data_out      <= RESET_WORD;
            out_valid     <= 1'b0;
            overflow      <= 1'b0;
            in_ready      <= 1'b1;
        end else begin
            state_q       <= state_d;
            bin_q         <= bin_d;
            bcd_q         <= bcd_d;
            cnt_q         <= cnt_d;
            ovf_pending_q <= ovf_pending_d;
            data_out      <= data_out_d;
            out_valid     <= out_valid_d;
            overflow      <= overflow_d;
            in_ready      <= in_ready_d;
        end
    end

    always_comb begin
        logic [BCD_W-1:0] bcd_adj;
        state_d       = state_q;
        bin_d         = bin_q;
        bcd_d         = bcd_q;
        cnt_d         = cnt_q;
        ovf_pending_d = ovf_pending_q;
        data_out_d    = data_out;
        out_valid_d   = 1'b0;
        overflow_d    = overflow;
        in_ready_d    = in_ready;
        bcd_adj       = add3(bcd_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d         = in_value;
                    bcd_d         = '0;
                    cnt_d         = '0;
                    ovf_pending_d = (in_value > MAX_VALUE);
                    in_ready_d    = 1'b0;
                    state_d       = CONVERT;
                end
            end
            CONVERT: begin
                // Adjust then shift {bcd, bin} left; bin MSB enters bcd LSB.
                bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SHIFT) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (ovf_pending_q) begin
                    data_out_d = OVF_CODE;
                end else if (BLANK_LEADING) begin
                    data_out_d = blank_leading(bcd_q);
                end else begin
                    data_out_d = bcd_q;
                end
                overflow_d  = ovf_pending_q;
                out_valid_d = 1'b1;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

endmodule
